data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Data-memory slave that answers load/store requests issued by the CPU memory stage over the req/ack data-memory interface. It holds a word-organised synchronous RAM and applies a configurable response latency. Stores are byte-lane masked per funct3. Loads are returned already sign- or zero-extended per funct3. It sits outside the 5-stage pipeline in the cpu top level, wired to the memory stage's request outputs and its ack/data inputs.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in RAM; power of two.
LATENCY, 1, number of wait cycles between request acceptance and the ack cycle; 0 is legal.

Ports:
i_clk  input  1  CPU clock
i_rst_n  input  1  reset; synchronous and active-low
i_mem_req  input  1  request valid; requester holds it and all fields stable until it sees o_mem_ack
i_mem_addr  input  32  byte address
i_mem_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
i_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_read_write  input  1  0 = read (load), 1 = write (store)
o_mem_ack  output  1  one-cycle response pulse
o_mem_data  output  32  load result; valid only while o_mem_ack=1
o_mem_err  output  1  error flag, valid only with o_mem_ack

Behaviour:
- FSM states:
  - IDLE: if i_mem_req=1, capture addr, data, funct3 and rw into registers. Go to WAIT if LATENCY>0, else go to RESP. Load wait counter with LATENCY-1.
  - WAIT: decrement counter each cycle. Go to RESP when counter=0. Inputs are ignored in this state; the captured copy is used.
  - RESP: drive o_mem_ack=1 for exactly one cycle, then go to IDLE.
- Latency: a request sampled in IDLE at cycle N is acked at cycle N+1+LATENCY.
- Back-to-back requests: if i_mem_req=1 in the cycle after the ack, i.e. in IDLE, it is a new request and is accepted. The requester must drop req or present the next request in that cycle.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Byte lane = addr[1:0].
- Error conditions, each reported as o_mem_err=1 together with the ack:
  - Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal funct3: 011, 110 or 111 on a read; anything other than 000/001/010 on a write.
  - Address out of range: any addr bit above log2(DEPTH_WORDS)+1 set.
  - On any error, no RAM write occurs and o_mem_data=0.
- Store: the RAM write commits on the RESP clock edge.
  - SB writes lane addr[1:0] from data[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} from data[15:0].
  - SW writes all four lanes.
  - Unselected lanes keep their value.
  - o_mem_data=0 on a store ack.
- Load: the RAM word is read in the state preceding RESP. It is registered so it is valid during the ack cycle.
  - B sign-extends the selected byte; BU zero-extends it.
  - H sign-extends the selected half; HU zero-extends it.
  - W returns the whole word.
- Outputs are registered.
- Reset:
  - Asserting i_rst_n=0 on a clock edge forces IDLE and clears o_mem_ack, o_mem_data, o_mem_err and the counter.
  - RAM contents are not cleared.
  - A reset arriving during WAIT or RESP aborts the transaction. No ack is issued, and no write occurs if reset coincides with the RESP edge.
- Between acks, o_mem_ack=0 and o_mem_err=0. o_mem_data holds 0 outside an ack.

Test Plan:
- Scenario 1, store then load word (LATENCY=1): SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> first ack 2 cycles after req with err=0; load ack returns 0xDEADBEEF.
- Scenario 2, byte and half lanes with extension: after SW 0x20=0x00000000, SB 0x23 data 0x000000F0, then SH 0x20 data 0x8001.
  - LW 0x20 -> 0xF0008001.
  - LB 0x23 -> 0xFFFFFFF0; LBU 0x23 -> 0x000000F0.
  - LH 0x20 -> 0xFFFF8001; LHU 0x20 -> 0x00008001.
- Scenario 3, errors: LW 0x22, SH 0x21, LW with funct3 011, and LW 0x00001000 (DEPTH_WORDS=1024).
  - Each -> ack with err=1 and data 0.
  - Following LW 0x20 still returns 0xF0008001, showing no corrupting write.
- Scenario 4, back-to-back and LATENCY sweep: hold req high across two consecutive LWs.
  - Acks exactly LATENCY+2 cycles apart.
  - Repeat with LATENCY=0 and LATENCY=3; ack at N+1 and N+4 respectively.
- Scenario 5, input change during WAIT: with LATENCY=3, SW 0x30=0x11111111, and change i_mem_addr/i_mem_data during WAIT -> captured values are used; LW 0x30 returns 0x11111111.
- Scenario 6, reset mid-operation: with LATENCY=3, SW 0x40=0xAAAAAAAA, then assert reset in WAIT for one cycle.
  - No ack follows.
  - Outputs are 0 during reset.
  - LW 0x40 afterwards returns the pre-existing contents, not 0xAAAAAAAA.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory slave for the CPU memory stage: a word-organised synchronous RAM
// behind a req/ack handshake. Each response arrives after a programmable wait.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_req,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic [2:0]  i_funct3,
  input  logic        i_read_write,
  output logic        o_mem_ack,
  output logic [31:0] o_mem_data,
  output logic        o_mem_err
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int AW = IW + 2;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q, wdata_q;
  logic [2:0]    f3_q;
  logic          rw_q;
  logic          ack_q, err_q;
  logic [31:0]   data_q;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic acc_err(input logic [31:0] a, input logic [2:0] f3,
                                   input logic rw);
    logic e;
    e = |a[31:AW];
    case (f3)
      3'b000, 3'b100: ;
      3'b001, 3'b101: e = e | a[0];
      3'b010:         e = e | (|a[1:0]);
      default:        e = 1'b1;
    endcase
    if (rw && f3[2]) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] ld_fmt(input logic [31:0] w, input logic [1:0] lane,
                                         input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      3'b010:  r = w;
      default: r = '0;
    endcase
    return r;
  endfunction

  // With zero latency the response is formed straight from the live inputs in
  // IDLE; otherwise it comes from the copy captured at acceptance.
  logic [31:0] cur_addr;
  logic [2:0]  cur_f3;
  logic        cur_rw;
  logic        cur_err;
  logic [31:0] rd_word;
  logic [31:0] resp_data;
  logic        enter_resp;

  always_comb begin
    cur_addr = addr_q;
    cur_f3   = f3_q;
    cur_rw   = rw_q;
    if (state_q == S_IDLE) begin
      cur_addr = i_mem_addr;
      cur_f3   = i_funct3;
      cur_rw   = i_read_write;
    end
    cur_err   = acc_err(cur_addr, cur_f3, cur_rw);
    rd_word   = mem[cur_addr[AW-1:2]];
    resp_data = (cur_err || cur_rw) ? 32'h0 : ld_fmt(rd_word, cur_addr[1:0], cur_f3);
    enter_resp = ((state_q == S_IDLE) && i_mem_req && (LATENCY == 0)) ||
                 ((state_q == S_WAIT) && (cnt_q == '0));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rw_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (i_mem_req) begin
            addr_q  <= i_mem_addr;
            wdata_q <= i_mem_data;
            f3_q    <= i_funct3;
            rw_q    <= i_read_write;
            cnt_q   <= CNT_INIT;
            state_q <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) state_q <= S_RESP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (enter_resp) begin
        ack_q  <= 1'b1;
        err_q  <= cur_err;
        data_q <= resp_data;
      end
    end
  end

  // Store lanes come from the captured request; the write lands on the edge
  // that closes the ack cycle, so a reset on that edge suppresses it.
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  always_comb begin
    wr_be   = 4'h0;
    wr_data = wdata_q;
    case (f3_q)
      3'b000: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      3'b010:  wr_be = 4'b1111;
      default: wr_be = 4'h0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && (state_q == S_RESP) && rw_q && !err_q) begin
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) mem[addr_q[AW-1:2]][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
  end

  assign o_mem_ack  = ack_q;
  assign o_mem_data = data_q;
  assign o_mem_err  = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (latency 1, 0, 3) driven by
// vector tables, hand sequences and random traffic checked against a byte model.
module tb_data_mem_responder;
  localparam int ND = 3;
  localparam int LATS[ND] = '{1, 0, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req[ND];
  logic [31:0] addr[ND];
  logic [31:0] wdat[ND];
  logic [2:0]  f3[ND];
  logic        rw[ND];
  logic        ack[ND];
  logic [31:0] rdat[ND];
  logic        err[ND];

  genvar g;
  generate
    for (g = 0; g < ND; g++) begin : g_dut
      data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LATS[g])) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_req(req[g]), .i_mem_addr(addr[g]),
        .i_mem_data(wdat[g]), .i_funct3(f3[g]), .i_read_write(rw[g]),
        .o_mem_ack(ack[g]), .o_mem_data(rdat[g]), .o_mem_err(err[g]));
    end
  endgenerate

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl[ND][64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference rules: byte address range, legal size codes, natural alignment.
  function automatic bit m_err(input logic [31:0] a, input logic [2:0] fc, input bit w);
    int sz;
    if (a >= 32'h1000) return 1'b1;
    if (w ? !(fc inside {3'd0, 3'd1, 3'd2}) : !(fc inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
      return 1'b1;
    sz = 1 << fc[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] m_load(input int d, input logic [31:0] a, input logic [2:0] fc);
    longint v;
    int n, lane;
    n = 1 << fc[1:0];
    lane = int'(a[1:0]);
    v = longint'(mdl[d][a[7:2]]) >> (8 * lane);
    if (n < 4) begin
      v = v & ((longint'(1) << (8 * n)) - 1);
      if (!fc[2] && v[8*n-1]) v = v - (longint'(1) << (8 * n));
    end
    return v[31:0];
  endfunction

  task automatic m_store(input int d, input logic [31:0] a, input logic [2:0] fc,
                         input logic [31:0] wd);
    logic [31:0] w;
    int n, lane;
    n = 1 << fc[1:0];
    lane = int'(a[1:0]);
    w = mdl[d][a[7:2]];
    for (int i = 0; i < n; i++) w[8*(lane+i) +: 8] = wd[8*i +: 8];
    mdl[d][a[7:2]] = w;
  endtask

  task automatic txn(input int d, input bit w, input logic [2:0] fc, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rv, output logic ev,
                     output int lat);
    bit got = 0;
    @(negedge clk);
    req[d] = 1'b1; rw[d] = w; f3[d] = fc; addr[d] = a; wdat[d] = wd;
    lat = -1; rv = 'x; ev = 1'bx;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (ack[d]) begin
        got = 1; lat = k; rv = rdat[d]; ev = err[d];
      end
    end
    req[d] = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout d%0d addr %h: no ack within 20 cycles", d, a);
    end
  endtask

  task automatic do_chk(input int d, input bit w, input logic [2:0] fc, input logic [31:0] a,
                        input logic [31:0] wd);
    logic [31:0] rv, ed;
    logic ev;
    bit ee;
    int lat;
    ee = m_err(a, fc, w);
    ed = (ee || w) ? 32'h0 : m_load(d, a, fc);
    txn(d, w, fc, a, wd, rv, ev, lat);
    chk($sformatf("d%0d data @%h f3=%0d rw=%0b", d, a, fc, w), rv, ed);
    chk($sformatf("d%0d err @%h f3=%0d rw=%0b", d, a, fc, w), {31'h0, ev}, {31'h0, ee});
    chk($sformatf("d%0d latency", d), lat, LATS[d] + 1);
    if (w && !ee) m_store(d, a, fc, wd);
  endtask

  typedef struct {
    bit          w;
    logic [2:0]  fc;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_d;
    bit          exp_e;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    logic ev;
    int lat, k1, k2;
    bit saw;

    for (int d = 0; d < ND; d++) begin
      req[d] = 0; rw[d] = 0; f3[d] = 0; addr[d] = 0; wdat[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d reset ack", d), {31'h0, ack[d]}, 32'h0);
      chk($sformatf("d%0d reset data", d), rdat[d], 32'h0);
      chk($sformatf("d%0d reset err", d), {31'h0, err[d]}, 32'h0);
    end
    rst_n = 1'b1;

    // Known contents for the model; word 16 (0x40) gets a fixed marker.
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 64; i++) begin
        logic [31:0] v;
        v = (i == 16) ? 32'h5A5A0F0F : $urandom;
        txn(d, 1'b1, 3'd2, 32'(i * 4), v, rv, ev, lat);
        mdl[d][i] = v;
      end

    tbl = '{
      '{1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        0},
      '{0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 0},
      '{1, 3'd2, 32'h20, 32'h0,        32'h0,        0},
      '{1, 3'd0, 32'h23, 32'h000000F0, 32'h0,        0},
      '{1, 3'd1, 32'h20, 32'h00008001, 32'h0,        0},
      '{0, 3'd2, 32'h20, 32'h0,        32'hF0008001, 0},
      '{0, 3'd0, 32'h23, 32'h0,        32'hFFFFFFF0, 0},
      '{0, 3'd4, 32'h23, 32'h0,        32'h000000F0, 0},
      '{0, 3'd1, 32'h20, 32'h0,        32'hFFFF8001, 0},
      '{0, 3'd5, 32'h20, 32'h0,        32'h00008001, 0},
      '{0, 3'd2, 32'h22, 32'h0,        32'h0,        1},
      '{1, 3'd1, 32'h21, 32'h0000FFFF, 32'h0,        1},
      '{0, 3'd3, 32'h20, 32'h0,        32'h0,        1},
      '{0, 3'd2, 32'h1000, 32'h0,      32'h0,        1},
      '{1, 3'd4, 32'h20, 32'hFFFFFFFF, 32'h0,        1},
      '{0, 3'd2, 32'h20, 32'h0,        32'hF0008001, 0},
      '{0, 3'd1, 32'h22, 32'h0,        32'hFFFFF000, 0},
      '{1, 3'd0, 32'h21, 32'h0000007F, 32'h0,        0},
      '{0, 3'd2, 32'h20, 32'h0,        32'hF0007F01, 0},
      '{0, 3'd0, 32'h21, 32'h0,        32'h0000007F, 0}
    };
    for (int i = 0; i < tbl.size(); i++) begin
      txn(0, tbl[i].w, tbl[i].fc, tbl[i].a, tbl[i].wd, rv, ev, lat);
      chk($sformatf("vec%0d data", i), rv, tbl[i].exp_d);
      chk($sformatf("vec%0d err", i), {31'h0, ev}, {31'h0, tbl[i].exp_e});
      chk($sformatf("vec%0d latency", i), lat, 2);
      if (tbl[i].w && !tbl[i].exp_e) m_store(0, tbl[i].a, tbl[i].fc, tbl[i].wd);
    end

    // Back-to-back: request held high across two loads.
    for (int d = 0; d < ND; d++) begin
      k1 = -1; k2 = -1;
      @(negedge clk);
      req[d] = 1; rw[d] = 0; f3[d] = 3'd2; addr[d] = 32'h10;
      for (int k = 1; k <= 30 && k2 < 0; k++) begin
        @(negedge clk);
        if (ack[d]) begin
          if (k1 < 0) k1 = k; else k2 = k;
        end
      end
      req[d] = 0;
      chk($sformatf("d%0d b2b first ack", d), k1, LATS[d] + 1);
      chk($sformatf("d%0d b2b ack spacing", d), k2 - k1, LATS[d] + 2);
    end

    // Inputs changing during WAIT must not affect the captured store.
    @(negedge clk);
    req[2] = 1; rw[2] = 1; f3[2] = 3'd2; addr[2] = 32'h30; wdat[2] = 32'h11111111;
    @(negedge clk);
    addr[2] = 32'h34; wdat[2] = 32'h22222222; f3[2] = 3'd0; rw[2] = 0;
    saw = 0;
    for (int k = 2; k <= 20 && !saw; k++) begin
      @(negedge clk);
      if (ack[2]) begin
        saw = 1;
        chk("wait-change store err", {31'h0, err[2]}, 32'h0);
        chk("wait-change ack time", k, 4);
      end
    end
    req[2] = 0;
    chk("wait-change ack seen", {31'h0, saw}, 32'h1);
    mdl[2][12] = 32'h11111111;
    txn(2, 1'b0, 3'd2, 32'h30, 32'h0, rv, ev, lat);
    chk("wait-change load 0x30", rv, 32'h11111111);
    do_chk(2, 1'b0, 3'd2, 32'h34, 32'h0);

    // Reset while in WAIT aborts the store.
    @(negedge clk);
    req[2] = 1; rw[2] = 1; f3[2] = 3'd2; addr[2] = 32'h40; wdat[2] = 32'hAAAAAAAA;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0; req[2] = 0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("d%0d mid-reset ack", d), {31'h0, ack[d]}, 32'h0);
      chk($sformatf("d%0d mid-reset data", d), rdat[d], 32'h0);
      chk($sformatf("d%0d mid-reset err", d), {31'h0, err[d]}, 32'h0);
    end
    rst_n = 1;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[2]) saw = 1;
    end
    chk("aborted store no ack", {31'h0, saw}, 32'h0);
    txn(2, 1'b0, 3'd2, 32'h40, 32'h0, rv, ev, lat);
    chk("aborted store load 0x40", rv, 32'h5A5A0F0F);

    // Random traffic against the byte model.
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 150; i++) begin
        logic [31:0] a;
        a = ($urandom % 8 == 0) ? (32'h1000 | ($urandom % 32'h10000)) : ($urandom % 256);
        do_chk(d, bit'($urandom % 2), 3'($urandom % 8), a, $urandom);
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
